// File: rtl/scope_raster.sv
// scope_raster: multi-channel oscilloscope trace rasteriser feeding the LT24 pixel port.
// Samples are double-buffered per channel; each frame is scanned x-fastest, one pixel per accept.
module scope_raster_lane #(
   parameter int XW = 8
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          load,
   input  logic [XW-1:0] cur,
   input  logic [XW-1:0] prv,
   input  logic [XW-1:0] px,
   output logic          hit
);
   logic [XW-1:0] lo, hi;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         lo <= '0;
         hi <= '0;
      end else if (load) begin
         lo <= (cur < prv) ? cur : prv;
         hi <= (cur < prv) ? prv : cur;
      end
   end

   assign hit = (px >= lo) && (px <= hi);
endmodule

module scope_raster #(
   parameter int          WIDTH       = 240,
   parameter int          HEIGHT      = 320,
   parameter int          CH          = 2,
   parameter int          GRID        = 40,
   parameter logic [15:0] BG_COLOUR   = 16'h0000,
   parameter logic [15:0] GRID_COLOUR = 16'h39E7,
   parameter logic [63:0] CH_COLOURS  = 64'h07E0_F81F_07FF_FFE0,
   localparam int         XW          = $clog2(WIDTH),
   localparam int         YW          = $clog2(HEIGHT),
   localparam int         CW          = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic          clock,
   input  logic          globalRst_n,
   input  logic          rstApp,
   input  logic          enable,
   input  logic          smpWrite,
   input  logic [CW-1:0] smpChan,
   input  logic [YW-1:0] smpIndex,
   input  logic [XW-1:0] smpValue,
   input  logic          swapReq,
   output logic [XW-1:0] xAddr,
   output logic [YW-1:0] yAddr,
   output logic [15:0]   pixelData,
   output logic          pixelWrite,
   input  logic          pixelReady,
   output logic          frameDone,
   output logic          swapPending,
   output logic          bank
);
   typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_t;

   state_t                 state;
   logic                   fph;
   logic [XW-1:0]          mem [0:1][0:CH-1][0:HEIGHT-1];
   logic                   ch_ok, idx_ok;
   logic [XW-1:0]          wr_val;
   logic [YW-1:0]          yp;
   logic [CH-1:0][XW-1:0]  cur, prv;
   logic [CH-1:0]          hit;
   logic [XW-1:0]          px;
   logic                   on_grid, load;
   logic [15:0]            colour;

   // Range guards collapse to constants when the index width exactly covers the range.
   if (CH == (1 << CW)) begin : g_ch_full
      assign ch_ok = 1'b1;
   end else begin : g_ch_part
      assign ch_ok = int'(smpChan) < CH;
   end
   if (HEIGHT == (1 << YW)) begin : g_idx_full
      assign idx_ok = 1'b1;
   end else begin : g_idx_part
      assign idx_ok = int'(smpIndex) < HEIGHT;
   end

   assign wr_val = (int'(smpValue) > WIDTH - 1) ? XW'(WIDTH - 1) : smpValue;

   // Sample memory: writes only ever land in the back bank, so the frame in flight is untouched.
   always_ff @(posedge clock) begin
      if (smpWrite && ch_ok && idx_ok)
         mem[~bank][smpChan][smpIndex] <= wr_val;
   end

   assign yp = (yAddr == '0) ? yAddr : yAddr - 1'b1;

   always_comb begin
      cur = '0;
      prv = '0;
      for (int n = 0; n < CH; n++) begin
         cur[n] = mem[bank][n][yAddr];
         prv[n] = mem[bank][n][yp];
      end
   end

   assign load = (state == FETCH) && !fph;
   assign px   = (state == DRAW) ? XW'(xAddr + 1'b1) : '0;

   for (genvar n = 0; n < CH; n++) begin : g_lane
      scope_raster_lane #(.XW(XW)) u_lane (
         .clock (clock),
         .rst_n (globalRst_n),
         .load  (load),
         .cur   (cur[n]),
         .prv   (prv[n]),
         .px    (px),
         .hit   (hit[n])
      );
   end

   if (GRID == 0) begin : g_nogrid
      assign on_grid = 1'b0;
   end else begin : g_grid
      assign on_grid = (int'(px) % GRID == 0) || (int'(yAddr) % GRID == 0);
   end

   // Colour of the pixel about to be presented; walk channels downwards so the lowest wins.
   always_comb begin
      colour = on_grid ? GRID_COLOUR : BG_COLOUR;
      for (int n = CH - 1; n >= 0; n--)
         if (hit[n]) colour = CH_COLOURS[16*n +: 16];
   end

   always_ff @(posedge clock or negedge globalRst_n) begin
      if (!globalRst_n) begin
         state       <= IDLE;
         fph         <= 1'b0;
         xAddr       <= '0;
         yAddr       <= '0;
         pixelData   <= BG_COLOUR;
         pixelWrite  <= 1'b0;
         frameDone   <= 1'b0;
         swapPending <= 1'b0;
         bank        <= 1'b0;
      end else begin
         frameDone <= 1'b0;
         if (swapReq) swapPending <= 1'b1;
         if (rstApp) begin
            state      <= IDLE;
            fph        <= 1'b0;
            xAddr      <= '0;
            yAddr      <= '0;
            pixelWrite <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  xAddr <= '0;
                  yAddr <= '0;
                  fph   <= 1'b0;
                  if (enable) state <= FETCH;
               end
               FETCH: begin
                  // Phase 0 latches the per-channel spans, phase 1 colours pixel x=0.
                  if (!fph) begin
                     fph <= 1'b1;
                  end else begin
                     fph        <= 1'b0;
                     pixelData  <= colour;
                     pixelWrite <= 1'b1;
                     state      <= DRAW;
                  end
               end
               DRAW: begin
                  if (pixelReady) begin
                     if (xAddr != XW'(WIDTH - 1)) begin
                        xAddr     <= xAddr + 1'b1;
                        pixelData <= colour;
                     end else begin
                        xAddr      <= '0;
                        pixelWrite <= 1'b0;
                        if (yAddr != YW'(HEIGHT - 1)) begin
                           yAddr <= yAddr + 1'b1;
                           state <= FETCH;
                        end else begin
                           yAddr     <= '0;
                           frameDone <= 1'b1;
                           if (swapPending || swapReq) begin
                              bank        <= ~bank;
                              swapPending <= 1'b0;
                           end
                           state <= enable ? FETCH : IDLE;
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_scope_raster.sv
// Randomised bench for scope_raster: a scan-order reference model checks every presented pixel,
// bank/swap state and frame pulses, with literal pixel expectations pinning the model.
module tb_scope_raster;
   localparam int W = 24, H = 20, NC = 3, G = 8;
   localparam logic [63:0] CHC = 64'h07E0_F81F_07FF_FFE0;

   logic clock = 1'b0;
   logic globalRst_n, rstApp, enable, smpWrite, swapReq, pixelReady;
   logic [1:0] smpChan;
   logic [4:0] smpIndex, smpValue, xAddr, yAddr;
   logic [15:0] pixelData;
   logic pixelWrite, frameDone, swapPending, bank;

   scope_raster #(.WIDTH(W), .HEIGHT(H), .CH(NC), .GRID(G)) dut (
      .clock(clock), .globalRst_n(globalRst_n), .rstApp(rstApp), .enable(enable),
      .smpWrite(smpWrite), .smpChan(smpChan), .smpIndex(smpIndex), .smpValue(smpValue),
      .swapReq(swapReq), .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
      .pixelWrite(pixelWrite), .pixelReady(pixelReady), .frameDone(frameDone),
      .swapPending(swapPending), .bank(bank));

   always #5 clock = ~clock;

   int total = 0, bad = 0;
   int smem [2][NC][H];
   int mbank = 0, mpend = 0, ex = 0, ey = 0, running = 0, acc = 0, fd_exp = 0;
   bit rnd_rdy = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Expected colour from sample values; -1 when a needed sample was never written.
   function automatic int colour_of(input int b, input int x, input int y);
      for (int n = 0; n < NC; n++) begin
         int c, p, lo, hi;
         c = smem[b][n][y];
         p = (y == 0) ? c : smem[b][n][y-1];
         if (c < 0 || p < 0) return -1;
         lo = (c < p) ? c : p;
         hi = (c < p) ? p : c;
         if (x >= lo && x <= hi) return int'(CHC[16*n +: 16]);
      end
      if (x % G == 0 || y % G == 0) return 16'h39E7;
      return 16'h0000;
   endfunction

   always @(posedge clock) begin
      #1;
      pixelReady = rnd_rdy ? ($urandom_range(0, 99) >= 30) : 1'b1;
   end

   // Compare current outputs with the model, then predict the effect of the coming edge.
   always @(negedge clock) begin
      if (!globalRst_n) begin
         mbank = 0; mpend = 0; ex = 0; ey = 0; running = 0; acc = 0; fd_exp = 0;
      end else begin
         int pend_in, c;
         chk("bank", int'(bank), mbank);
         chk("swapPending", int'(swapPending), mpend);
         chk("frameDone", int'(frameDone), fd_exp);
         if (!running) chk("idle_nopix", int'(pixelWrite), 0);
         if (pixelWrite) begin
            chk("xAddr", int'(xAddr), ex);
            chk("yAddr", int'(yAddr), ey);
            c = colour_of(mbank, ex, ey);
            if (c >= 0) chk("pixelData", int'(pixelData), c);
         end
         fd_exp = 0;
         if (smpWrite && smpChan < NC && smpIndex < H)
            smem[1-mbank][smpChan][smpIndex] = (smpValue > W-1) ? W-1 : int'(smpValue);
         pend_in = (mpend != 0 || swapReq) ? 1 : 0;
         if (rstApp) begin
            running = 0; ex = 0; ey = 0; acc = 0; mpend = pend_in;
         end else if (!running) begin
            if (enable) running = 1;
            mpend = pend_in;
         end else if (pixelWrite && pixelReady) begin
            acc++;
            mpend = pend_in;
            if (ex < W-1) ex++;
            else begin
               ex = 0;
               if (ey < H-1) ey++;
               else begin
                  ey = 0;
                  fd_exp = 1;
                  chk("frame_accepts", acc, W*H);
                  acc = 0;
                  if (pend_in != 0) mbank = 1 - mbank;
                  mpend = 0;
                  running = enable ? 1 : 0;
               end
            end
         end else mpend = pend_in;
      end
   end

   task automatic wr(input int ch, input int idx, input int val);
      @(posedge clock); #1;
      smpWrite = 1'b1; smpChan = 2'(ch); smpIndex = 5'(idx); smpValue = 5'(val);
      @(posedge clock); #1;
      smpWrite = 1'b0;
   endtask

   task automatic pulse_swap();
      @(posedge clock); #1 swapReq = 1'b1;
      @(posedge clock); #1 swapReq = 1'b0;
   endtask

   task automatic wait_pix(input int x, input int y);
      int found = 0;
      for (int i = 0; i < 4000 && found == 0; i++) begin
         @(negedge clock);
         if (pixelWrite && xAddr == 5'(x) && yAddr == 5'(y)) found = 1;
      end
      chk($sformatf("reach_%0d_%0d", x, y), found, 1);
   endtask

   task automatic wait_fd();
      int found = 0;
      for (int i = 0; i < 4000 && found == 0; i++) begin
         @(negedge clock);
         if (frameDone) found = 1;
      end
      chk("reach_frameDone", found, 1);
   endtask

   initial begin
      for (int b = 0; b < 2; b++)
         for (int n = 0; n < NC; n++)
            for (int i = 0; i < H; i++) smem[b][n][i] = -1;
      globalRst_n = 1'b0; rstApp = 1'b0; enable = 1'b0; smpWrite = 1'b0; swapReq = 1'b0;
      smpChan = '0; smpIndex = '0; smpValue = '0; pixelReady = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_x", int'(xAddr), 0);
      chk("rst_y", int'(yAddr), 0);
      chk("rst_data", int'(pixelData), 16'h0000);
      chk("rst_pw", int'(pixelWrite), 0);
      chk("rst_fd", int'(frameDone), 0);
      chk("rst_swp", int'(swapPending), 0);
      chk("rst_bank", int'(bank), 0);
      globalRst_n = 1'b1;

      // Back bank 1: flat ch0=10, ch1 saturates to 23, ch2 ramps 3+y; two ignored writes.
      for (int i = 0; i < H; i++) begin
         wr(0, i, 10); wr(1, i, 31); wr(2, i, 3 + i);
      end
      wr(3, 0, 0);
      wr(0, 25, 0);
      pulse_swap();
      @(posedge clock); #1 enable = 1'b1;
      wait_fd();
      chk("bank_after_swap", int'(bank), 1);

      wait_pix(8, 3);   chk("lit_grid_8_3", int'(pixelData), 16'h39E7);
      wait_pix(9, 3);   chk("lit_bg_9_3", int'(pixelData), 16'h0000);
      wait_pix(10, 3);  chk("lit_ch0_10_3", int'(pixelData), 16'hFFE0);
      wait_pix(7, 5);   chk("lit_ch2_7_5", int'(pixelData), 16'hF81F);
      wait_pix(23, 5);  chk("lit_ch1_sat_23_5", int'(pixelData), 16'h07FF);
      wait_pix(10, 16); chk("lit_prio_10_16", int'(pixelData), 16'hFFE0);

      // Random back bank 0, then a known span on ch0 rows 4..5.
      for (int n = 0; n < NC; n++)
         for (int i = 0; i < H; i++) wr(n, i, int'($urandom_range(0, 31)));
      wr(0, 4, 20); wr(0, 5, 12);
      rnd_rdy = 1;
      pulse_swap();
      wait_fd();
      wait_pix(15, 5); chk("lit_span_15_5", int'(pixelData), 16'hFFE0);
      wait_fd();

      // swapReq on the same edge as the final accept.
      rnd_rdy = 0;
      wait_pix(W-2, H-1);
      @(posedge clock); #1 swapReq = 1'b1;
      @(posedge clock); #1 swapReq = 1'b0;
      @(negedge clock);
      chk("coinc_fd", int'(frameDone), 1);
      chk("coinc_bank", int'(bank), 1);
      chk("coinc_swp", int'(swapPending), 0);

      // rstApp mid-row.
      wait_pix(13, 7);
      @(posedge clock); #1 rstApp = 1'b1;
      @(posedge clock); #1 rstApp = 1'b0;
      chk("rstapp_pw", int'(pixelWrite), 0);
      chk("rstapp_x", int'(xAddr), 0);
      chk("rstapp_y", int'(yAddr), 0);
      wait_pix(0, 0);

      // enable dropped mid-frame: the frame finishes, then the scan stays idle.
      rnd_rdy = 1;
      wait_pix(5, 10);
      @(posedge clock); #1 enable = 1'b0;
      wait_fd();
      repeat (30) @(negedge clock);
      chk("idle_after_enable", int'(pixelWrite), 0);

      // Asynchronous reset in the middle of DRAW.
      @(posedge clock); #1 enable = 1'b1;
      wait_pix(3, 2);
      @(posedge clock); #3 globalRst_n = 1'b0;
      #1;
      chk("arst_x", int'(xAddr), 0);
      chk("arst_y", int'(yAddr), 0);
      chk("arst_data", int'(pixelData), 16'h0000);
      chk("arst_pw", int'(pixelWrite), 0);
      chk("arst_bank", int'(bank), 0);
      @(posedge clock); #1 globalRst_n = 1'b1;
      wait_pix(0, 0);
      wait_fd();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
